// File: rtl/int_muldiv_unit_pkg.sv
// Shared execution-stage definitions: integer opcodes (also used by the ALU
// decode), the mul/div FSM state encoding and the step-counter width helper.
package int_muldiv_unit_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_MUL = 4'b0011;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0100;
  localparam logic [OP_W-1:0] OP_MOD = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W_DEFAULT = $clog2(32 + 1);

endpackage

// File: rtl/int_muldiv_unit_if.sv
// Request/response bundle between the issue logic and the mul/div unit.
interface int_muldiv_unit_if
  import int_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic              is_signed;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  Z;
  logic              div_by_zero;
  logic              stall;

  modport master (
    output in_valid, op, is_signed, A, B, flush, out_ready,
    input  in_ready, out_valid, Z, div_by_zero, stall
  );

  modport slave (
    input  in_valid, op, is_signed, A, B, flush, out_ready,
    output in_ready, out_valid, Z, div_by_zero, stall
  );

endinterface

// File: rtl/int_muldiv_unit_muldiv_step.sv
// One iteration of the iterative datapath. MUL: MSB-first shift-add into the
// accumulator (rem). DIV/MOD: one restoring-division step, quotient bits
// shifted into quo while the dividend bits shift out of its top.
module muldiv_step
  import int_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_mul,
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic signed [WIDTH:0] shifted;
  logic signed [WIDTH:0] diff;
  logic [WIDTH-1:0]      acc;

  // Select shift-add or restore-subtract for this iteration.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - $signed({1'b0, dvs});
    acc     = {rem_in[WIDTH-2:0], 1'b0} + (quo_in[WIDTH-1] ? dvs : '0);
    rem_out = shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (is_mul) begin
      rem_out = acc;
    end else if (!diff[WIDTH]) begin
      rem_out    = diff[WIDTH-1:0];
      quo_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/int_muldiv_unit.sv
// Iterative integer multiply/divide/modulo unit. Works on operand magnitudes
// for WIDTH cycles, then applies the sign fix-up and holds the result until
// the consumer takes it.
module int_muldiv_unit
  import int_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  int_muldiv_unit_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] z_q;
  logic             dbz_out_q;

  logic [OP_W-1:0]  op_q;
  logic             neg_q;
  logic             dbz_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             step_is_mul;

  logic             accept_slot;
  logic             acc_arith;
  logic             acc_neg;
  logic             acc_dbz;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sg);
    return (sg && v[WIDTH-1]) ? -v : v;
  endfunction

  // The most-negative dividend has no positive twin, but its magnitude read as
  // unsigned is exact, so overflow cases come out right without special paths.
  function automatic logic [WIDTH-1:0] fixup(input logic [OP_W-1:0] op,
                                             input logic neg,
                                             input logic dbz,
                                             input logic [WIDTH-1:0] rem,
                                             input logic [WIDTH-1:0] quo);
    logic [WIDTH-1:0] r;
    case (op)
      OP_MUL:  r = rem;
      OP_DIV:  r = quo;
      OP_MOD:  r = rem;
      default: r = '0;
    endcase
    if (neg) r = -r;
    if (dbz && (op == OP_DIV)) r = '1;
    return r;
  endfunction

  assign accept_slot = (state == S_IDLE) && bus.in_valid;
  assign mag_a       = magnitude(bus.A, bus.is_signed);
  assign mag_b       = magnitude(bus.B, bus.is_signed);
  assign step_is_mul = (op_q == OP_MUL);

  // Result sign and divide-by-zero are decided once, from the raw operands.
  always_comb begin
    acc_arith = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
    acc_dbz   = ((bus.op == OP_DIV) || (bus.op == OP_MOD)) && (bus.B == '0);
    if (bus.op == OP_MOD) begin
      acc_neg = bus.is_signed & bus.A[WIDTH-1];
    end else begin
      acc_neg = bus.is_signed & acc_arith & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_mul  (step_is_mul),
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Operand capture at accept, then one datapath iteration per BUSY cycle.
  always_ff @(posedge clk) begin
    if (accept_slot) begin
      op_q  <= bus.op;
      neg_q <= acc_neg;
      dbz_q <= acc_dbz;
      rem_q <= '0;
      if (bus.op == OP_MUL) begin
        quo_q <= mag_b;
        dvs_q <= mag_a;
      end else begin
        quo_q <= mag_a;
        dvs_q <= mag_b;
      end
    end else if (state == S_BUSY) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  // FSM, step counter and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      z_q       <= '0;
      dbz_out_q <= 1'b0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            state <= S_BUSY;
            cnt   <= CNT_W'(WIDTH);
          end
        end
        S_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= S_DONE;
            z_q       <= fixup(op_q, neg_q, dbz_q, rem_nx, quo_nx);
            dbz_out_q <= dbz_q;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.Z           = z_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.stall       = (state == S_BUSY) ||
                           ((state == S_DONE) && !bus.out_ready) ||
                           (bus.in_valid && !bus.in_ready);

endmodule

// File: tb/tb_int_muldiv_unit.sv
// Directed and randomised checks of int_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_int_muldiv_unit;
  import int_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_muldiv_unit_if #(.WIDTH(32)) b32();
  int_muldiv_unit_if #(.WIDTH(8))  b8();

  int_muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  int_muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [3:0] op, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
    b32.op = op; b32.is_signed = sg; b32.A = a; b32.B = b; b32.in_valid = 1'b1;
  endtask

  // Issue one op with out_ready high and wait for its result (bounded).
  task automatic run32(input logic [3:0] op, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output logic dbz,
                       output int lat, output logic stall_ok);
    drive32(op, sg, a, b);
    b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    lat = 0;
    stall_ok = 1'b1;
    while (!b32.out_valid && lat < 100) begin
      if (b32.stall !== 1'b1) stall_ok = 1'b0;
      tick();
      lat++;
    end
    z = b32.Z;
    dbz = b32.div_by_zero;
    tick();
  endtask

  task automatic bus_drive(input int w, input logic iv, input logic [3:0] op,
                           input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic fl, input logic ordy);
    if (w == 32) begin
      b32.in_valid = iv; b32.op = op; b32.is_signed = sg; b32.A = a; b32.B = b;
      b32.flush = fl; b32.out_ready = ordy;
    end else begin
      b8.in_valid = iv; b8.op = op; b8.is_signed = sg; b8.A = a[7:0]; b8.B = b[7:0];
      b8.flush = fl; b8.out_ready = ordy;
    end
  endtask

  task automatic bus_sample(input int w, output logic ov, output logic ir,
                            output logic [31:0] z, output logic dbz);
    if (w == 32) begin
      ov = b32.out_valid; ir = b32.in_ready; z = b32.Z; dbz = b32.div_by_zero;
    end else begin
      ov = b8.out_valid; ir = b8.in_ready; z = {24'b0, b8.Z}; dbz = b8.div_by_zero;
    end
  endtask

  // Reference: wide native arithmetic on sign-extended operands.
  function automatic logic [31:0] ref_res(input int w, input logic [3:0] op, input logic sg,
                                          input logic [31:0] a_in, input logic [31:0] b_in,
                                          output logic dbz);
    longint sa, sb, r;
    logic [31:0] mask, a, b;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a = a_in & mask;
    b = b_in & mask;
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    dbz = 1'b0;
    r = 0;
    case (op)
      OP_MUL: r = sa * sb;
      OP_DIV: if (b == 0) begin dbz = 1'b1; r = -1; end else r = sa / sb;
      OP_MOD: if (b == 0) begin dbz = 1'b1; r = sa; end else r = sa % sb;
      default: r = 0;
    endcase
    return r[31:0] & mask;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus_drive(32, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus_drive(8,  1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) tick();
    n_cmp++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.stall !== 1'b0)
      begin n_err++; $display("FAIL reset_ctrl: got in_ready=%b out_valid=%b stall=%b expected 1 0 0", b32.in_ready, b32.out_valid, b32.stall); end
    n_cmp++;
    if (b32.Z !== 32'd0 || b32.div_by_zero !== 1'b0)
      begin n_err++; $display("FAIL reset_data: got Z=%h dbz=%b expected 0 0", b32.Z, b32.div_by_zero); end
    n_cmp++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.Z !== 8'd0)
      begin n_err++; $display("FAIL reset_w8: got in_ready=%b out_valid=%b Z=%h expected 1 0 00", b8.in_ready, b8.out_valid, b8.Z); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    logic [31:0] z; logic dbz; int lat; logic sok;
    run32(OP_MUL, 1'b0, 32'd7, 32'd6, z, dbz, lat, sok);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL mul_latency: got %0d expected 32", lat); end
    n_cmp++; if (z !== 32'd42) begin n_err++; $display("FAIL mul_z: got %h expected %h", z, 32'd42); end
    n_cmp++; if (sok !== 1'b1) begin n_err++; $display("FAIL mul_stall: stall dropped while busy"); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL mul_dbz: got %b expected 0", dbz); end
    run32(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mul_signed: got %h expected FFFFFFF1", z); end
  endtask

  task automatic test_divmod();
    logic [31:0] z; logic dbz; int lat; logic sok;
    run32(OP_DIV, 1'b0, 32'd100, 32'd7, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'd14 || lat !== 32) begin n_err++; $display("FAIL div_u: got %h lat %0d expected 0000000e lat 32", z, lat); end
    run32(OP_MOD, 1'b0, 32'd100, 32'd7, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'd2) begin n_err++; $display("FAIL mod_u: got %h expected 00000002", z); end
    run32(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_s: got %h expected FFFFFFFD", z); end
    run32(OP_MOD, 1'b1, 32'hFFFF_FFF9, 32'd2, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mod_s: got %h expected FFFFFFFF", z); end
    run32(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL div_u_big: got %h expected 7FFFFFFC", z); end
    run32(OP_MOD, 1'b1, 32'd7, 32'hFFFF_FFFE, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'd1) begin n_err++; $display("FAIL mod_s_negdivisor: got %h expected 00000001", z); end
  endtask

  task automatic test_div_zero();
    logic [31:0] z; logic dbz; int lat; logic sok;
    run32(OP_DIV, 1'b0, 32'd55, 32'd0, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'hFFFF_FFFF || dbz !== 1'b1 || lat !== 32)
      begin n_err++; $display("FAIL div_zero: got Z=%h dbz=%b lat=%0d expected FFFFFFFF 1 32", z, dbz, lat); end
    run32(OP_MOD, 1'b0, 32'd55, 32'd0, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'd55 || dbz !== 1'b1)
      begin n_err++; $display("FAIL mod_zero: got Z=%h dbz=%b expected 00000037 1", z, dbz); end
    run32(OP_DIV, 1'b1, 32'hFFFF_FFC9, 32'd0, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'hFFFF_FFFF || dbz !== 1'b1)
      begin n_err++; $display("FAIL div_zero_s: got Z=%h dbz=%b expected FFFFFFFF 1", z, dbz); end
  endtask

  task automatic test_overflow();
    logic [31:0] z; logic dbz; int lat; logic sok;
    run32(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'h8000_0000 || dbz !== 1'b0)
      begin n_err++; $display("FAIL ovf_div: got Z=%h dbz=%b expected 80000000 0", z, dbz); end
    run32(OP_MOD, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, z, dbz, lat, sok);
    n_cmp++; if (z !== 32'd0 || dbz !== 1'b0)
      begin n_err++; $display("FAIL ovf_mod: got Z=%h dbz=%b expected 00000000 0", z, dbz); end
  endtask

  task automatic test_backpressure();
    int lat;
    drive32(OP_MUL, 1'b0, 32'd9, 32'd9);
    b32.out_ready = 1'b0;
    tick();
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 100) begin tick(); lat++; end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL bp_latency: got %0d expected 32", lat); end
    drive32(OP_MUL, 1'b0, 32'd3, 32'd5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (b32.Z !== 32'd81 || b32.out_valid !== 1'b1 || b32.stall !== 1'b1 || b32.in_ready !== 1'b0)
        begin n_err++; $display("FAIL bp_hold[%0d]: got Z=%h ov=%b stall=%b ir=%b expected 00000051 1 1 0", i, b32.Z, b32.out_valid, b32.stall, b32.in_ready); end
      tick();
    end
    b32.out_ready = 1'b1;
    tick();
    n_cmp++; if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0)
      begin n_err++; $display("FAIL bp_release: got ir=%b ov=%b expected 1 0", b32.in_ready, b32.out_valid); end
    tick();
    n_cmp++; if (b32.in_ready !== 1'b0)
      begin n_err++; $display("FAIL bp_next_accept: got ir=%b expected 0", b32.in_ready); end
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 100) begin tick(); lat++; end
    n_cmp++; if (lat !== 32 || b32.Z !== 32'd15)
      begin n_err++; $display("FAIL bp_next_result: got Z=%h lat=%0d expected 0000000f 32", b32.Z, lat); end
    tick();
  endtask

  task automatic test_flush();
    logic seen;
    drive32(OP_DIV, 1'b0, 32'd1000, 32'd3);
    b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    repeat (9) tick();
    b32.flush = 1'b1;
    tick();
    b32.flush = 1'b0;
    n_cmp++; if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0)
      begin n_err++; $display("FAIL flush_idle: got ir=%b ov=%b expected 1 0", b32.in_ready, b32.out_valid); end
    seen = 1'b0;
    repeat (40) begin if (b32.out_valid) seen = 1'b1; tick(); end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_result: got out_valid pulse expected none"); end
    drive32(OP_MUL, 1'b0, 32'd2, 32'd2);
    b32.flush = 1'b1;
    tick();
    b32.flush = 1'b0;
    b32.in_valid = 1'b0;
    n_cmp++; if (b32.in_ready !== 1'b1)
      begin n_err++; $display("FAIL flush_blocks_accept: got ir=%b expected 1", b32.in_ready); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive32(OP_DIV, 1'b0, 32'd1000, 32'd3);
    b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.Z !== 32'd0 || b32.div_by_zero !== 1'b0)
      begin n_err++; $display("FAIL reset_mid: got ir=%b ov=%b Z=%h dbz=%b expected 1 0 00000000 0", b32.in_ready, b32.out_valid, b32.Z, b32.div_by_zero); end
    seen = 1'b0;
    repeat (40) begin if (b32.out_valid) seen = 1'b1; tick(); end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL reset_no_result: got out_valid pulse expected none"); end
  endtask

  task automatic test_random(input int w, input int n_ops);
    int accepted, flushed, results, guard, r;
    logic [3:0] op; logic sg, fl, ordy, done, seen, ov, ir, dbz, edbz;
    logic [31:0] a, b, z, exp_z;
    accepted = 0; flushed = 0; results = 0;
    for (int i = 0; i < n_ops; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? OP_MUL : (r < 6) ? OP_DIV : (r < 9) ? OP_MOD : 4'($urandom_range(0, 15));
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      else if (r == 1) b = 32'hFFFF_FFFF;
      else if (r == 2) b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) a = 32'd1 << (w - 1);
      exp_z = ref_res(w, op, sg, a, b, edbz);
      bus_drive(w, 1'b1, op, sg, a, b, 1'b0, 1'($urandom_range(0, 1)));
      tick();
      accepted++;
      done = 1'b0; seen = 1'b0; guard = 0;
      while (!done && guard < 300) begin
        fl = ($urandom_range(0, 299) == 0);
        ordy = ($urandom_range(0, 3) != 0);
        bus_drive(w, 1'b0, op, sg, a, b, fl, ordy);
        bus_sample(w, ov, ir, z, dbz);
        if (ov && !seen) begin
          seen = 1'b1;
          n_cmp++;
          if (guard !== w) begin n_err++; $display("FAIL rand%0d_latency[%0d]: got %0d expected %0d", w, i, guard, w); end
        end
        if (fl) begin
          flushed++;
          done = 1'b1;
        end else if (ov && ordy) begin
          results++;
          done = 1'b1;
          n_cmp++;
          if (z !== exp_z || dbz !== edbz)
            begin n_err++; $display("FAIL rand%0d_result[%0d]: op=%h sg=%b A=%h B=%h got Z=%h dbz=%b expected Z=%h dbz=%b", w, i, op, sg, a, b, z, dbz, exp_z, edbz); end
        end
        tick();
        guard++;
      end
      bus_drive(w, 1'b0, op, sg, a, b, 1'b0, 1'b0);
      if (!done) begin
        n_cmp++; n_err++;
        $display("FAIL rand%0d_timeout[%0d]: got no result within 300 cycles expected one", w, i);
      end
      bus_sample(w, ov, ir, z, dbz);
      n_cmp++;
      if (ov !== 1'b0 || ir !== 1'b1)
        begin n_err++; $display("FAIL rand%0d_after[%0d]: got ov=%b ir=%b expected 0 1", w, i, ov, ir); end
    end
    n_cmp++;
    if (results !== accepted - flushed)
      begin n_err++; $display("FAIL rand%0d_count: got %0d results expected %0d", w, results, accepted - flushed); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divmod();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random(32, 1000);
    test_random(8, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
